// File: rtl/alu_result_stage.sv
// alu_result_stage
//
// Execute-stage output register behind the 64-bit ALU. Each accepted beat
// carries its result, destination register, write enable and a resolved
// branch decision into a two-entry slot pair (main slot + skid slot). The
// stage also owns the architectural NZCV flag register.
//
// Handshake: a beat moves across an interface in any cycle where valid and
// ready are both high at the rising edge. in_ready does not depend on
// in_valid. While out_valid=1 and out_ready=0, out_valid and all out_* hold
// steady.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   in_valid / in_ready             upstream handshake
//   in_result                       ALU result (WIDTH bits)
//   in_zero/overflow/carry_out/negative   ALU flags for this beat
//   in_set_flags                    beat updates NZCV
//   in_rd, in_reg_write             destination register and write enable
//   in_is_bcond/is_cbz/is_cbnz      branch kind, in_cond = B.cond condition code
//   out_valid / out_ready           downstream handshake
//   out_result, out_rd, out_reg_write, out_branch_taken   registered beat
//   flags                           NZCV register {N,Z,C,V}

module alu_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic             in_carry_out,
    input  logic             in_negative,
    input  logic             in_set_flags,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic             in_is_bcond,
    input  logic             in_is_cbz,
    input  logic             in_is_cbnz,
    input  logic [3:0]       in_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_branch_taken,
    output logic [3:0]       flags
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [4:0]       rd;
        logic             reg_write;
        logic             taken;
    } beat_t;

    beat_t      main_q;
    beat_t      skid_q;
    beat_t      in_beat;
    logic       main_valid;
    logic       skid_valid;
    logic [3:0] nzcv_q;
    logic       accept;
    logic       deliver;
    logic       cond_taken;
    logic       branch_taken;
    logic       f_n, f_z, f_c, f_v;

    assign {f_n, f_z, f_c, f_v} = nzcv_q;

    // B.cond is judged against the register as it stands before this beat's
    // own flag update, so an ADDS/SUBS that is also a B.cond sees older flags.
    always_comb begin
        cond_taken = 1'b1;
        case (in_cond)
            4'h0:    cond_taken = f_z;
            4'h1:    cond_taken = !f_z;
            4'h2:    cond_taken = f_c;
            4'h3:    cond_taken = !f_c;
            4'h4:    cond_taken = f_n;
            4'h5:    cond_taken = !f_n;
            4'h6:    cond_taken = f_v;
            4'h7:    cond_taken = !f_v;
            4'h8:    cond_taken = f_c && !f_z;
            4'h9:    cond_taken = !f_c || f_z;
            4'hA:    cond_taken = (f_n == f_v);
            4'hB:    cond_taken = (f_n != f_v);
            4'hC:    cond_taken = !f_z && (f_n == f_v);
            4'hD:    cond_taken = f_z || (f_n != f_v);
            default: cond_taken = 1'b1;
        endcase
    end

    // CBZ/CBNZ: the ALU passes the tested register through, so in_zero is
    // the zero test of that register.
    always_comb begin
        branch_taken = 1'b0;
        if (in_is_bcond) begin
            branch_taken = cond_taken;
        end else if (in_is_cbz) begin
            branch_taken = in_zero;
        end else if (in_is_cbnz) begin
            branch_taken = !in_zero;
        end
    end

    always_comb begin
        in_beat.result    = in_result;
        in_beat.rd        = in_rd;
        in_beat.reg_write = in_reg_write;
        in_beat.taken     = branch_taken;
    end

    assign in_ready = !skid_valid && !reset;
    assign accept   = in_valid && in_ready;
    assign deliver  = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            nzcv_q     <= 4'b0000;
        end else begin
            if (accept && in_set_flags) begin
                nzcv_q <= {in_negative, in_zero, in_carry_out, in_overflow};
            end
            // in_ready is low whenever the skid slot is full, so an accept
            // can never coincide with the skid-to-main transfer.
            if (skid_valid && deliver) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept && (!main_valid || deliver)) begin
                main_q     <= in_beat;
                main_valid <= 1'b1;
            end else begin
                // Remaining accept case: main is full and stalled.
                if (accept) begin
                    skid_q     <= in_beat;
                    skid_valid <= 1'b1;
                end
                if (deliver) begin
                    main_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid        = main_valid;
    assign out_result       = main_q.result;
    assign out_rd           = main_q.rd;
    assign out_reg_write    = main_q.reg_write;
    assign out_branch_taken = main_q.taken;
    assign flags            = nzcv_q;

endmodule
